// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: per-FU holding registers, round-robin grant, registered broadcast.
// Define CDB_PARITY_EN to add the registered even-parity output cdbparity.
module cdb_arbiter #(
    parameter int FU_COUNT = 8,
    parameter int DATA_W   = 8,
    parameter int TAG_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [FU_COUNT-1:0]          fu_done,
    input  logic [FU_COUNT*DATA_W-1:0]   fu_result,
    input  logic [FU_COUNT*TAG_W-1:0]    fu_tag,
    output logic [FU_COUNT-1:0]          fu_ready,
    output logic [FU_COUNT-1:0]          fus_busy,
    output logic [DATA_W-1:0]            cdbval,
    output logic [TAG_W-1:0]             cdbid,
`ifdef CDB_PARITY_EN
    output logic                         cdbparity,
`endif
    output logic                         cdbtransmit,
    output logic [$clog2(FU_COUNT)-1:0]  cdbfu
);

    localparam int IDX_W = $clog2(FU_COUNT);

    logic [FU_COUNT-1:0] hold_v;
    logic [DATA_W-1:0]   hold_val [FU_COUNT];
    logic [TAG_W-1:0]    hold_tag [FU_COUNT];

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_next;

    logic [FU_COUNT-1:0] grant;
    logic                grant_v;
    logic [IDX_W-1:0]    grant_idx;
    logic [FU_COUNT-1:0] capture;

    logic [DATA_W-1:0]   win_val;
    logic [TAG_W-1:0]    win_tag;

    // Round-robin scan starting at rr_ptr; the first pending entry wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] scan;
        sum       = '0;
        scan      = '0;
        grant_v   = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int off = 0; off < FU_COUNT; off++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(FU_COUNT)) begin
                sum = sum - (IDX_W+1)'(FU_COUNT);
            end
            scan = sum[IDX_W-1:0];
            if (!grant_v && hold_v[scan] && !flush) begin
                grant_v   = 1'b1;
                grant_idx = scan;
            end
        end
        if (grant_v) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (grant_v) begin
            if (grant_idx == IDX_W'(FU_COUNT - 1)) begin
                rr_next = '0;
            end else begin
                rr_next = grant_idx + 1'b1;
            end
        end
    end

    // A granted entry drains this edge, so it may refill in the same cycle.
    assign fu_ready = ~hold_v | grant;
    assign capture  = fu_done & fu_ready & {FU_COUNT{~flush}};
    assign fus_busy = hold_v;

    assign win_val = hold_val[grant_idx];
    assign win_tag = hold_tag[grant_idx];

    for (genvar i = 0; i < FU_COUNT; i++) begin : g_hold
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_v[i]   <= 1'b0;
                hold_val[i] <= '0;
                hold_tag[i] <= '0;
            end else if (flush) begin
                hold_v[i]   <= 1'b0;
            end else if (capture[i]) begin
                hold_v[i]   <= 1'b1;
                hold_val[i] <= fu_result[i*DATA_W +: DATA_W];
                hold_tag[i] <= fu_tag[i*TAG_W +: TAG_W];
            end else if (grant[i]) begin
                hold_v[i]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdbtransmit <= 1'b0;
            cdbval      <= '0;
            cdbid       <= '0;
            cdbfu       <= '0;
        end else if (grant_v) begin
            cdbtransmit <= 1'b1;
            cdbval      <= win_val;
            cdbid       <= win_tag;
            cdbfu       <= grant_idx;
        end else begin
            cdbtransmit <= 1'b0;
            cdbval      <= '0;
            cdbid       <= '0;
            cdbfu       <= '0;
        end
    end

`ifdef CDB_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdbparity <= 1'b0;
        end else if (grant_v) begin
            cdbparity <= ^{win_val, win_tag};
        end else begin
            cdbparity <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Transmit end of the common data bus (CDB). Collects completed results from the functional units, arbitrates one per cycle with round-robin priority, and drives the registered cdbval/cdbid/cdbtransmit broadcast. The issuer and its reservation stations snoop this broadcast. The block also exports per-FU busy status that feeds the issuer's fus_busy input.

Parameters:
FU_COUNT, 8, number of functional units / result sources.
DATA_W, 8, result width; must equal the cdbval width.
TAG_W, 4, dependency tag width; must equal the cdbid width.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  synchronous flush of all pending results (mispredict/recovery).
fu_done  input  FU_COUNT  per-FU result valid.
fu_result  input  FU_COUNT x DATA_W  per-FU result value.
fu_tag  input  FU_COUNT x TAG_W  per-FU destination tag.
fu_ready  output  FU_COUNT  per-FU result accept (combinational).
fus_busy  output  FU_COUNT  per-FU holding register occupied; goes to the issuer.
cdbval  output  DATA_W  broadcast value (registered).
cdbid  output  TAG_W  broadcast tag (registered).
cdbtransmit  output  1  broadcast valid (registered).
cdbfu  output  clog2(FU_COUNT)  index of the FU whose result is on the bus (registered).

Behaviour:
- Reset (rst=0, async): all hold_v=0; rr_ptr=0; cdbtransmit=0; cdbval=0; cdbid=0; cdbfu=0. fus_busy=0 and fu_ready=all-ones immediately.
- State per FU i: one-entry holding register with fields hold_v, hold_val, hold_tag.
- fu_ready[i] = !hold_v[i] | grant[i]. Back-to-back results from one FU are accepted while its entry drains.
- Capture: fu_done[i] & fu_ready[i] & !flush loads hold_val/hold_tag and sets hold_v at the edge.
- fu_done while fu_ready=0: the FU must hold its done/result/tag stable until accepted. The arbiter ignores the request until then.
- Arbitration (combinational, each cycle):
  - grant = first set hold_v scanning rr_ptr, rr_ptr+1, ..., wrapping mod FU_COUNT.
  - At most one grant bit is set.
  - grant is forced to 0 when flush=1.
- Broadcast register, at each edge:
  - If a grant exists: cdbtransmit<=1, cdbval<=hold_val[g], cdbid<=hold_tag[g], cdbfu<=g; hold_v[g] is cleared unless refilled the same cycle; rr_ptr<=(g+1) mod FU_COUNT.
  - Else: cdbtransmit<=0, cdbval<=0, cdbid<=0, cdbfu<=0; rr_ptr unchanged.
- Latency: fu_done accepted at edge N, eligible in cycle N+1, earliest on the bus after edge N+1. That is 2 cycles done-to-cdbtransmit.
- Throughput: 1 broadcast/cycle. A result waits at most FU_COUNT-1 cycles after becoming eligible.
- Simultaneous grant and refill on the same FU: the entry is overwritten with the new result and hold_v stays 1. The old value goes to the bus.
- fus_busy[i] = hold_v[i] (registered state, no combinational path from fu_done).
- flush=1:
  - At the edge: all hold_v<=0, cdbtransmit<=0 (cdbval/cdbid/cdbfu<=0), rr_ptr unchanged.
  - fu_done is ignored that cycle.
  - A broadcast already on the bus during the flush cycle is not retracted.
- Reset asserted mid-operation: pending results are lost and outputs return to reset values asynchronously.

Optional Feature:
CDB_PARITY_EN.
- Defined: adds output cdbparity (1 bit, registered alongside cdbval) = even parity, i.e. XOR of cdbval and cdbid bits. It is 0 on reset, when idle, and on flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then FU2 done with val=0x5A, tag=0x3 for one cycle -> fu_ready[2]=1; fus_busy[2]=1 the next cycle; two cycles after the done edge cdbtransmit=1, cdbval=0x5A, cdbid=0x3, cdbfu=2; idle (transmit=0) the following cycle.
- All 8 FUs done in one cycle, val=0x10+i, tag=i, rr_ptr=0 -> 8 consecutive broadcasts with cdbfu 0..7 and cdbval 0x10..0x17; fus_busy clears one bit per cycle; no gaps.
- Fairness: rr_ptr=6 after granting FU5; FU1 and FU7 are pending -> FU7 is broadcast first, then FU1; rr_ptr ends at 2.
- Back-to-back: FU4 presents 0xA1, 0xA2, 0xA3 on consecutive cycles with no other requesters -> fu_ready[4] stays 1; the bus carries 0xA1, 0xA2, 0xA3 on three consecutive cycles.
- Stall: FU0 and FU1 pending and FU0 done again while its entry is ungranted -> fu_ready[0]=0; the result is held until FU0 is granted, then accepted; no result is lost or duplicated.
- Flush with 3 entries pending -> next cycle cdbtransmit=0 and fus_busy=0; a concurrent fu_done is dropped; rst pulsed low mid-burst -> outputs go to 0 asynchronously.
